// File: rtl/pc_gen_if.sv
// Fetch-address generator bus: redirect requests, stall and memory handshake
// in, fetch address and status pulses out.
interface pc_gen_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  trap_en_i;
  logic [ADDR_WIDTH-1:0] trap_addr_i;
  logic                  jmp_en_i;
  logic [ADDR_WIDTH-1:0] jmp_addr_i;
  logic                  hold_i;
  logic                  fetch_ready_i;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic                  pc_valid_o;
  logic                  flush_o;
  logic                  misalign_o;
  logic                  redirect_pending_o;

  // Core/pipeline side: drives redirects, stall and memory ready.
  modport master (
    output trap_en_i, trap_addr_i, jmp_en_i, jmp_addr_i, hold_i, fetch_ready_i,
    input  pc_o, pc_valid_o, flush_o, misalign_o, redirect_pending_o
  );

  // PC generator side.
  modport slave (
    input  trap_en_i, trap_addr_i, jmp_en_i, jmp_addr_i, hold_i, fetch_ready_i,
    output pc_o, pc_valid_o, flush_o, misalign_o, redirect_pending_o
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential increment on accepted fetches, trap/jump
// redirects (trap first), redirect capture while stalled, target alignment
// and a one-cycle flush pulse on every applied redirect.
module pc_gen #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RST_ADDR   = '0,
  parameter int                    INC        = 4,
  parameter int                    ALIGN_BITS = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_gen_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [ADDR_WIDTH-1:0] INC_W = ADDR_WIDTH'(INC);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  vld_q, vld_d;
  logic                  flush_q, flush_d;
  logic                  misalign_q, misalign_d;
  logic                  pend_vld_q, pend_vld_d;
  logic                  pend_trap_q, pend_trap_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;

  logic                  redir_act;
  logic [ADDR_WIDTH-1:0] redir_addr;

  // Redirect source selection: live trap, pending trap, live jump, pending jump.
  always_comb begin
    redir_act  = bus.trap_en_i | pend_vld_q | bus.jmp_en_i;
    redir_addr = pend_addr_q;
    if (bus.trap_en_i) begin
      redir_addr = bus.trap_addr_i;
    end else if (pend_vld_q && pend_trap_q) begin
      redir_addr = pend_addr_q;
    end else if (bus.jmp_en_i) begin
      redir_addr = bus.jmp_addr_i;
    end
  end

  // Next-state: redirect beats sequential fetch; a stall only captures redirects.
  always_comb begin
    pc_d        = pc_q;
    vld_d       = 1'b1;
    flush_d     = 1'b0;
    misalign_d  = 1'b0;
    pend_vld_d  = pend_vld_q;
    pend_trap_d = pend_trap_q;
    pend_addr_d = pend_addr_q;
    if (!bus.hold_i) begin
      if (redir_act) begin
        // The in-flight fetch is abandoned, so memory ready is irrelevant here.
        pc_d       = redir_addr & ~ALIGN_MASK;
        misalign_d = |(redir_addr & ALIGN_MASK);
        flush_d    = 1'b1;
        pend_vld_d  = 1'b0;
        pend_trap_d = 1'b0;
      end else if (vld_q && bus.fetch_ready_i) begin
        pc_d = pc_q + INC_W;
      end
    end else begin
      if (bus.trap_en_i) begin
        pend_vld_d  = 1'b1;
        pend_trap_d = 1'b1;
        pend_addr_d = bus.trap_addr_i;
      end else if (bus.jmp_en_i && !(pend_vld_q && pend_trap_q)) begin
        // A captured trap outranks any later jump, which is then dropped.
        pend_vld_d  = 1'b1;
        pend_trap_d = 1'b0;
        pend_addr_d = bus.jmp_addr_i;
      end
    end
  end

  // State registers; reset clears everything including any captured redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RST_ADDR;
      vld_q       <= 1'b0;
      flush_q     <= 1'b0;
      misalign_q  <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_trap_q <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      pc_q        <= pc_d;
      vld_q       <= vld_d;
      flush_q     <= flush_d;
      misalign_q  <= misalign_d;
      pend_vld_q  <= pend_vld_d;
      pend_trap_q <= pend_trap_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign bus.pc_o               = pc_q;
  assign bus.pc_valid_o         = vld_q;
  assign bus.flush_o            = flush_q;
  assign bus.misalign_o         = misalign_q;
  assign bus.redirect_pending_o = pend_vld_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed cycles push expected outputs into a
// queue; monitors pop and compare after each clock edge and after async reset.
module tb_pc_gen;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        vld;
    logic        flush;
    logic        mis;
    logic        pend;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic arm_rst_chk = 1'b0;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  pc_gen_if #(.ADDR_WIDTH(32)) bus ();

  pc_gen #(
    .ADDR_WIDTH(32),
    .RST_ADDR  (32'h8000_0000),
    .INC       (4),
    .ALIGN_BITS(2)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, req);
    end
  endtask

  task automatic compare_top();
    exp_t e;
    e = exp_q.pop_front();
    chk(e.name, "pc",       bus.pc_o,                       e.pc);
    chk(e.name, "valid",    {31'd0, bus.pc_valid_o},        {31'd0, e.vld});
    chk(e.name, "flush",    {31'd0, bus.flush_o},           {31'd0, e.flush});
    chk(e.name, "misalign", {31'd0, bus.misalign_o},        {31'd0, e.mis});
    chk(e.name, "pending",  {31'd0, bus.redirect_pending_o}, {31'd0, e.pend});
  endtask

  // Monitor: compare the state produced by each clock edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) compare_top();
  end

  // Monitor: compare the state right after an asynchronous reset assertion.
  always @(negedge rst_n) begin
    if (arm_rst_chk) begin
      #1;
      if (exp_q.size() > 0) compare_top();
      arm_rst_chk = 1'b0;
    end
  end

  // One cycle: drive inputs at the falling edge, queue the post-edge expectation.
  task automatic cyc(input string nm, input logic rst,
                     input logic te, input logic [31:0] ta,
                     input logic je, input logic [31:0] ja,
                     input logic hold, input logic rdy,
                     input logic [31:0] e_pc, input logic e_v, input logic e_f,
                     input logic e_m, input logic e_p);
    exp_t e;
    @(negedge clk);
    rst_n             = rst;
    bus.trap_en_i     = te;
    bus.trap_addr_i   = ta;
    bus.jmp_en_i      = je;
    bus.jmp_addr_i    = ja;
    bus.hold_i        = hold;
    bus.fetch_ready_i = rdy;
    e.name = nm; e.pc = e_pc; e.vld = e_v; e.flush = e_f; e.mis = e_m; e.pend = e_p;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    bus.trap_en_i = 0; bus.trap_addr_i = '0; bus.jmp_en_i = 0; bus.jmp_addr_i = '0;
    bus.hold_i = 0; bus.fetch_ready_i = 0;

    //    name        rst te ta            je ja            hd rdy  pc            v f m p
    cyc("rst0",        0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h8000_0000, 0,0,0,0);
    cyc("rst1",        0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h8000_0000, 0,0,0,0);
    cyc("vld_rise",    1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h8000_0000, 1,0,0,0);
    cyc("seq1",        1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h8000_0004, 1,0,0,0);
    cyc("seq2",        1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h8000_0008, 1,0,0,0);
    cyc("seq3",        1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h8000_000C, 1,0,0,0);
    cyc("seq4",        1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h8000_0010, 1,0,0,0);
    cyc("stall_a",     1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h8000_0010, 1,0,0,0);
    cyc("stall_b",     1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h8000_0010, 1,0,0,0);
    cyc("rdy_back",    1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h8000_0014, 1,0,0,0);
    cyc("jmp_mis",     1, 0, 32'h0,        1, 32'h0000_1236, 0, 0, 32'h0000_1234, 1,1,1,0);
    cyc("jmp_after",   1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_1234, 1,0,0,0);
    cyc("hold_jmp",    1, 0, 32'h0,        1, 32'h0000_2000, 1, 1, 32'h0000_1234, 1,0,0,1);
    cyc("hold_trap",   1, 1, 32'h0000_0100, 0, 32'h0,        1, 1, 32'h0000_1234, 1,0,0,1);
    cyc("hold_jdrop",  1, 0, 32'h0,        1, 32'h0000_3000, 1, 1, 32'h0000_1234, 1,0,0,1);
    cyc("hold_idle",   1, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0000_1234, 1,0,0,1);
    cyc("pend_apply",  1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0100, 1,1,0,0);
    cyc("post_apply",  1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_0104, 1,0,0,0);
    cyc("hold_j1",     1, 0, 32'h0,        1, 32'h0000_5000, 1, 1, 32'h0000_0104, 1,0,0,1);
    cyc("hold_j2",     1, 0, 32'h0,        1, 32'h0000_5008, 1, 1, 32'h0000_0104, 1,0,0,1);
    cyc("pend_jmp",    1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_5008, 1,1,0,0);
    cyc("both",        1, 1, 32'h0000_0200, 1, 32'h0000_4000, 0, 1, 32'h0000_0200, 1,1,0,0);
    cyc("trap_mis",    1, 1, 32'h0000_0303, 0, 32'h0,        0, 0, 32'h0000_0300, 1,1,1,0);
    cyc("hold_j3",     1, 0, 32'h0,        1, 32'h0000_6000, 1, 0, 32'h0000_0300, 1,0,0,1);
    cyc("hold_t3",     1, 1, 32'h0000_7000, 0, 32'h0,        1, 0, 32'h0000_0300, 1,0,0,1);
    cyc("ptrap_vs_j",  1, 0, 32'h0,        1, 32'h0000_9000, 0, 1, 32'h0000_7000, 1,1,0,0);
    cyc("to_top",      1, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1,1,0,0);
    cyc("wrap",        1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_0000, 1,0,0,0);
    cyc("hold_j4",     1, 0, 32'h0,        1, 32'h0000_ABC0, 1, 0, 32'h0000_0000, 1,0,0,1);

    // Asynchronous reset mid-cycle with a redirect pending.
    @(negedge clk);
    e.name = "async_rst"; e.pc = 32'h8000_0000; e.vld = 0; e.flush = 0; e.mis = 0; e.pend = 0;
    exp_q.push_back(e);
    arm_rst_chk = 1'b1;
    rst_n = 1'b0;
    #2;

    cyc("rst_hold",    0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h8000_0000, 0,0,0,0);
    cyc("rel2",        1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h8000_0000, 1,0,0,0);
    cyc("rel2_seq",    1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h8000_0004, 1,0,0,0);

    // Every queued expectation must have been consumed by the monitors.
    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
